dac_wave_seq: RTL

- Waveform sequencer directly upstream of the DAC SPI master. It produces periodic 12-bit samples and hands each one over with a data/address/command word plus the dactrig/dacdone handshake.
- Takes debounced less/more pulses to adjust amplitude, and SW to pick the waveform and channel.
- Replaces the simple manual controller in the DAC top level. LED outputs are for debug.

---
 rtl/dac_wave_seq_if.sv | 30 +++
 rtl/dac_wave_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dac_wave_seq_if.sv
// DAC word handshake between the waveform sequencer and the DAC SPI master.
//   data     12  DAC sample code
//   address   4  DAC channel (0000 A .. 0011 D)
//   command   4  DAC command word
//   dactrig   1  one-cycle start pulse, sequencer -> SPI master
//   dacdone   1  one-cycle completion pulse, SPI master -> sequencer
// Modports: master (sequencer side), slave (SPI master side).
interface dac_wave_seq_if;
  logic [11:0] data;
  logic [3:0]  address;
  logic [3:0]  command;
  logic        dactrig;
  logic        dacdone;

  modport master (
    output data,
    output address,
    output command,
    output dactrig,
    input  dacdone
  );

  modport slave (
    input  data,
    input  address,
    input  command,
    input  dactrig,
    output dacdone
  );
endinterface

// File: rtl/dac_wave_seq.sv
// Periodic waveform sequencer feeding the DAC SPI master.
// A tick every DIV cycles advances a 12-bit phase accumulator; when idle, the
// tick launches one LOAD/TRIG/WAIT transaction carrying the shaped sample.
// Ports:
//   CLK50MHZ  system clock
//   RST       asynchronous active-low reset
//   less/more one-cycle amplitude down/up pulses
//   SW        [1:0] waveform (DC, ramp, triangle, square), [3:2] channel
//   LED       [7] sticky overrun, [6] busy, [5:0] amp[11:6]
//   dac       handshake to the SPI master (master modport)
// Optional feature macro DACSEQ_ALLCH_EN: each tick issues a burst on channels
// A..D; A-C carry the sample, D carries amp-sample, SW[3:2] is ignored.
module dac_wave_seq #(
  parameter int unsigned DIV       = 5000,
  parameter int unsigned PHASE_INC = 16,
  parameter int unsigned AMP_STEP  = 256,
  parameter int unsigned AMP_RST   = 2048
) (
  input  logic           CLK50MHZ,
  input  logic           RST,
  input  logic           less,
  input  logic           more,
  input  logic [3:0]     SW,
  output logic [7:0]     LED,
  dac_wave_seq_if.master dac
);

  localparam logic [15:0] DivLast  = 16'(DIV - 1);
  localparam logic [11:0] PhaseInc = 12'(PHASE_INC);
  localparam logic [12:0] AmpStep  = 13'(AMP_STEP);
  localparam logic [11:0] AmpRst   = 12'(AMP_RST);
  localparam logic [3:0]  CmdWrUpd = 4'b0011;

  typedef enum logic [1:0] {StIdle, StLoad, StTrig, StWait} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [11:0] phase_q;
  logic [11:0] amp_q, amp_d;
  logic        overrun_q;
  logic        tick;
`ifdef DACSEQ_ALLCH_EN
  logic [1:0]  ch_q;
`endif

  assign tick = (cnt_q == DivLast);

  // Saturating amplitude update; simultaneous less+more cancels.
  logic [12:0] amp_up;
  always_comb begin
    amp_up = {1'b0, amp_q} + AmpStep;
    amp_d  = amp_q;
    if (more && !less) begin
      amp_d = amp_up[12] ? 12'hfff : amp_up[11:0];
    end else if (less && !more) begin
      amp_d = ({1'b0, amp_q} < AmpStep) ? 12'h000 : amp_q - AmpStep[11:0];
    end
  end

  // Waveform shaping from the already-advanced phase.
  logic [11:0] tri_fold, tri_val, mult_op, scaled, unused_lo, sample;
  always_comb begin
    // 4095 - s is the bitwise complement for a 12-bit s.
    tri_fold = phase_q[11] ? ~phase_q : phase_q;
    tri_val  = {tri_fold[10:0], 1'b0};
    mult_op  = SW[1] ? tri_val : phase_q;
    {scaled, unused_lo} = mult_op * amp_q;
    unique case (SW[1:0])
      2'b00:        sample = amp_q;
      2'b01, 2'b10: sample = scaled;
      default:      sample = phase_q[11] ? amp_q : 12'h000;
    endcase
  end

  // Timebase, phase accumulator and amplitude.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      phase_q <= '0;
      amp_q   <= AmpRst;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 16'd1;
      if (tick) phase_q <= phase_q + PhaseInc;
      amp_q <= amp_d;
    end
  end

  // Transaction FSM with registered handshake and LED outputs.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      dac.data    <= '0;
      dac.address <= '0;
      dac.command <= CmdWrUpd;
      dac.dactrig <= 1'b0;
      overrun_q   <= 1'b0;
      LED         <= '0;
`ifdef DACSEQ_ALLCH_EN
      ch_q        <= '0;
`endif
    end else begin
      LED <= {overrun_q, state_q != StIdle, amp_q[11:6]};
      // A tick that finds the FSM busy (including the dacdone cycle) is dropped.
      if (tick && state_q != StIdle) overrun_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (tick) state_q <= StLoad;
        end
        StLoad: begin
`ifdef DACSEQ_ALLCH_EN
          dac.address <= {2'b00, ch_q};
          dac.data    <= (ch_q == 2'd3) ? amp_q - sample : sample;
`else
          dac.address <= {2'b00, SW[3:2]};
          dac.data    <= sample;
`endif
          dac.command <= CmdWrUpd;
          dac.dactrig <= 1'b1;
          state_q     <= StTrig;
        end
        StTrig: begin
          dac.dactrig <= 1'b0;
          state_q     <= StWait;
        end
        StWait: begin
          if (dac.dacdone) begin
`ifdef DACSEQ_ALLCH_EN
            if (ch_q == 2'd3) begin
              ch_q    <= '0;
              state_q <= StIdle;
            end else begin
              ch_q    <= ch_q + 2'd1;
              state_q <= StLoad;
            end
`else
            state_q <= StIdle;
`endif
          end
        end
      endcase
    end
  end

endmodule
